// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access sequencer for the RV32I M stage.
// Turns one load or store into a single-port bus transaction and stalls the
// pipeline while it is outstanding. Load data comes back lane-aligned and
// sign- or zero-extended.
module dmem_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LD_REQ,
    input  logic [31:0] LD_ADDR,
    input  logic [2:0]  LD_FUNCT3,
    input  logic        ST_REQ,
    input  logic [31:0] ST_ADDR,
    input  logic [3:0]  ST_STRB,
    input  logic [31:0] ST_DATA,
    output logic        STALL,
    output logic        DATA_RDVALID,
    output logic [31:0] DATA_RDDATA,
    output logic        MISALIGN,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_STRB,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_GNT,
    input  logic        MEM_RVALID,
    input  logic [31:0] MEM_RDATA
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_RWAIT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;

    logic [1:0]  state;
    logic [2:0]  ld_funct3_q;
    logic [1:0]  ld_lane_q;
    logic        is_load_q;
    logic        misalign_q;
    logic [31:0] rddata_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_strb_q;
    logic [31:0] mem_wdata_q;

    logic        ld_misalign;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    // Classify the incoming load: misaligned halfword/word or undefined type.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        ld_misalign = 1'b0;
        case (LD_FUNCT3)
            F_LB, F_LBU: ld_misalign = 1'b0;
            F_LH, F_LHU: ld_misalign = LD_ADDR[0];
            F_LW:        ld_misalign = |LD_ADDR[1:0];
            default:     ld_misalign = 1'b1;
        endcase
    end

    // Select the addressed lane of the read word and extend it per load type.
    always_comb begin
        rd_byte = 8'h00;
        rd_half = ld_lane_q[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
        rd_ext  = 32'h0;
        case (ld_lane_q)
            2'd0: rd_byte = MEM_RDATA[7:0];
            2'd1: rd_byte = MEM_RDATA[15:8];
            2'd2: rd_byte = MEM_RDATA[23:16];
            2'd3: rd_byte = MEM_RDATA[31:24];
            default: rd_byte = 8'h00;
        endcase
        case (ld_funct3_q)
            F_LB:    rd_ext = {{24{rd_byte[7]}}, rd_byte};
            F_LBU:   rd_ext = {24'h0, rd_byte};
            F_LH:    rd_ext = {{16{rd_half[15]}}, rd_half};
            F_LHU:   rd_ext = {16'h0, rd_half};
            F_LW:    rd_ext = MEM_RDATA;
            default: rd_ext = 32'h0;
        endcase
    end

    // Sequencer: accept a request in IDLE, run the bus handshake, report in DONE.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_IDLE;
            ld_funct3_q <= 3'b000;
            ld_lane_q   <= 2'b00;
            is_load_q   <= 1'b0;
            misalign_q  <= 1'b0;
            rddata_q    <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_strb_q  <= 4'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ST_REQ) begin
                        // Stores win over a simultaneous load request.
                        is_load_q  <= 1'b0;
                        misalign_q <= 1'b0;
                        if (ST_STRB != 4'h0) begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= ST_ADDR & ~32'h3;
                            mem_strb_q  <= ST_STRB;
                            mem_wdata_q <= ST_DATA;
                            state       <= S_REQ;
                        end else begin
                            state <= S_DONE;
                        end
                    end else if (LD_REQ) begin
                        is_load_q   <= 1'b1;
                        ld_funct3_q <= LD_FUNCT3;
                        ld_lane_q   <= LD_ADDR[1:0];
                        // Cleared here so a skipped (misaligned) load returns 0.
                        rddata_q    <= 32'h0;
                        if (ld_misalign) begin
                            misalign_q <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            misalign_q <= 1'b0;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= LD_ADDR & ~32'h3;
                            mem_strb_q <= 4'h0;
                            state      <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (MEM_GNT) begin
                        mem_req_q <= 1'b0;
                        state     <= mem_we_q ? S_DONE : S_RWAIT;
                    end
                end
                S_RWAIT: begin
                    if (MEM_RVALID) begin
                        rddata_q <= rd_ext;
                        state    <= S_DONE;
                    end
                end
                // DONE ignores LD_REQ/ST_REQ: they still name the finished instruction.
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stall the pipeline while a request is pending or in flight.
    always_comb begin
        STALL = 1'b0;
        if (!RST) begin
            STALL = ((state == S_IDLE) && (LD_REQ || ST_REQ)) ||
                    (state == S_REQ) || (state == S_RWAIT);
        end
    end

    assign DATA_RDVALID = (state == S_DONE) && is_load_q;
    assign MISALIGN     = (state == S_DONE) && misalign_q;
    assign DATA_RDDATA  = rddata_q;
    assign MEM_REQ      = mem_req_q;
    assign MEM_WE       = mem_we_q;
    assign MEM_ADDR     = mem_addr_q;
    assign MEM_STRB     = mem_strb_q;
    assign MEM_WDATA    = mem_wdata_q;

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access sequencer for the RV32I core. It sits beside the memory-read (M) pipeline stage and turns that stage's load or store into a transaction on the single-port data-memory bus. While the access is outstanding it stalls the pipeline. For loads it returns byte-aligned, sign- or zero-extended read data on DATA_RDVALID/DATA_RDDATA, which the M stage muxes into its destination-register value.

## Interface
- No parameters. Widths are fixed by RV32I: 32-bit address and data, 4-bit strobe.
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, synchronous, active-high
- LD_REQ  in  1  the M-stage instruction is a valid load
- LD_ADDR  in  32  load byte address
- LD_FUNCT3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ST_REQ  in  1  the M-stage instruction is a valid store
- ST_ADDR  in  32  store byte address
- ST_STRB  in  4  store byte strobe, already lane-shifted
- ST_DATA  in  32  store data, already lane-shifted
- STALL  out  1  hold all pipeline registers this cycle
- DATA_RDVALID  out  1  DATA_RDDATA is valid; asserted only in state DONE
- DATA_RDDATA  out  32  aligned and extended load result
- MISALIGN  out  1  one-cycle pulse in DONE when the load address is misaligned
- MEM_REQ  out  1  bus request; held high until MEM_GNT
- MEM_WE  out  1  1 = write, 0 = read
- MEM_ADDR  out  32  word address; bits [1:0] are forced to 00
- MEM_STRB  out  4  write strobe; 0000 for reads
- MEM_WDATA  out  32  write data
- MEM_GNT  in  1  the slave accepts the request this cycle
- MEM_RVALID  in  1  read data valid; earliest one cycle after MEM_GNT
- MEM_RDATA  in  32  read data

## Operation
**States:** IDLE, REQ, RWAIT, DONE.

**IDLE**
- ST_REQ=1 has priority, even if LD_REQ is also 1:
  - If ST_STRB≠0, latch ST_ADDR/STRB/DATA into the MEM_* registers and go to REQ with MEM_WE=1.
  - If ST_STRB=0, issue no bus access and go to DONE.
- LD_REQ=1 alone:
  - Latch LD_FUNCT3 and LD_ADDR[1:0].
  - Misaligned means LH/LHU with addr[0]=1, LW with addr[1:0]≠00, or an undefined funct3.
  - If misaligned, issue no bus access, set the misalign flag and go to DONE.
  - Otherwise go to REQ with MEM_WE=0 and MEM_STRB=0000.

**REQ**
- MEM_REQ=1, and all MEM_* outputs stay stable until MEM_GNT.
- On MEM_GNT, drop MEM_REQ. A write goes to DONE; a read goes to RWAIT.

**RWAIT**
- MEM_RVALID is sampled only in this state.
- On MEM_RVALID, register the extended data and go to DONE.
- There is no timeout.

**DONE**
- DATA_RDVALID=1 for loads; MISALIGN=1 if the flag is set.
- Always return to IDLE. LD_REQ/ST_REQ are ignored in this cycle because they still describe the same instruction.

**Extension:**
- Byte lane k = addr[1:0]; halfword lane = addr[1].
- LB/LH sign-extend from bit 7/15 of the selected lane.
- LBU/LHU zero-extend.
- LW passes the word through unchanged.
- For a misaligned load, DATA_RDDATA=0.

**STALL** = (IDLE & (LD_REQ|ST_REQ)) | REQ | RWAIT. It is combinational from LD_REQ/ST_REQ. It is 0 in DONE and forced to 0 while RST=1.

**No abort:** once a request is issued, it always completes; there is no flush input.

## Timing
**Reset values:** state IDLE; STALL, DATA_RDVALID, MISALIGN, MEM_REQ, MEM_WE = 0; DATA_RDDATA, MEM_ADDR, MEM_STRB, MEM_WDATA = 0.

**Reset mid-transaction:** RST abandons the transaction immediately. The bus slave must be reset in the same cycle.

**Load** (request seen in IDLE at cycle t, zero-wait slave):
- t+1: REQ with MEM_GNT
- t+2: RWAIT with MEM_RVALID
- t+3: DONE, DATA_RDVALID=1, STALL=0
- The M stage is occupied for 4 cycles. Each GNT or RVALID wait cycle adds one.

**Store:**
- t+1: REQ with GNT
- t+2: DONE
- Occupancy is 3 cycles.

**Skipped accesses** (misaligned load, or store with ST_STRB=0): IDLE at t, DONE at t+1; 2 cycles.

**Back-to-back requests:** a new request can be accepted in IDLE on the cycle directly after DONE.

**Output registering:** MEM_* outputs are registered and never change combinationally from bus inputs.

## Test plan
- **LW, zero-wait:** LD_REQ, addr 0x100, RDATA 0xDEADBEEF → MEM_ADDR=0x100 at t+1; DATA_RDDATA=0xDEADBEEF with RDVALID at t+3; STALL=1 for t..t+2 only.
- **LB/LBU:** addr 0x103, RDATA 0x80FF_0000 → LB returns 0xFFFFFF80; LBU returns 0x00000080. LH at 0x102 → 0xFFFF80FF.
- **Store with delays:** SW to 0x200, data 0x12345678, strb 1111, GNT delayed 3 cycles → MEM_* stable and MEM_REQ=1 for 4 cycles; DONE one cycle after GNT; MEM_WE=1.
- **Misaligned / empty:** LW at 0x101 → no MEM_REQ, MISALIGN pulse at t+1, DATA_RDDATA=0. Store with ST_STRB=0000 → no MEM_REQ, DONE at t+1.
- **Simultaneous and back-to-back:** LD_REQ and ST_REQ both 1 → write issued. A load request held through DONE is not reissued; a new load in the next cycle is accepted.
- **Reset mid-read:** RST asserted in RWAIT → next cycle IDLE, all outputs 0, and a late MEM_RVALID is ignored.
